if_stage_sram: RTL and testbench

// - Instruction-fetch stage (pre-IF + IF) directly upstream of decode.
// - Generates fetch PCs and drives an SRAM-like inst port (req/addr_ok/data_ok), one outstanding request.
// - Buffers one {pc,inst} and hands it to decode with valid/allowin.
// - Consumes decode's br_bus to redirect fetch and squash wrong-path instructions.

---
 rtl/if_stage_sram.sv | 153 +++++++++++++++
 tb/tb_if_stage_sram.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_sram.sv
// ---------------------------------------------------------------------------
// if_stage_sram
// Instruction-fetch stage (pre-IF + IF) feeding decode.
//   - Generates fetch PCs and drives an SRAM-like instruction port
//     (req / addr_ok / data_ok), keeping at most one request outstanding.
//   - Buffers one {pc, inst} and hands it to decode via valid/allowin.
//   - Consumes decode's br_bus to redirect fetch and squash wrong-path work.
//
// Optional feature macro: IF_ADEF_CHK_EN
//   defined   : a misaligned fetch address issues no SRAM request; the slot is
//               loaded with {addr, 32'h0} and fs_adef is raised while held.
//   undefined : inst_sram_addr[1:0] is forced to 2'b00 and fs_adef is 0.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   ds_allowin          decode can accept an instruction this cycle
//   br_bus              {br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid      fs_to_ds_bus holds a valid instruction
//   fs_to_ds_bus        {fs_pc[31:0], fs_inst[31:0]}
//   fs_adef             fetch-address exception flag for the held fs_pc
//   inst_sram_req       fetch request
//   inst_sram_addr      fetch address
//   inst_sram_addr_ok   request accepted this cycle
//   inst_sram_data_ok   read data valid this cycle
//   inst_sram_rdata     instruction word
// ---------------------------------------------------------------------------
module if_stage_sram #(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       fs_adef,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  logic [31:0] pf_pc;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_inst_ok;
  logic        req_pend;
  logic        discard;

  logic        br_taken;
  logic [31:0] br_target;
  logic        br_ev;
  logic        ds_leave;
  logic        issue;
  logic [31:0] fetch_pc;
  logic        handshake;
`ifdef IF_ADEF_CHK_EN
  logic        adef_r;
  logic        adef_load;
`endif

  assign {br_taken, br_target} = br_bus;

  always_comb begin
    br_ev          = br_taken & ds_allowin;
    // br_taken gates valid so decode never latches a wrong-path instruction
    // in the cycle the branch leaves.
    fs_to_ds_valid = fs_valid & fs_inst_ok & ~br_taken;
    ds_leave       = fs_to_ds_valid & ds_allowin;
    issue          = ~reset & ~req_pend & ~discard & (~fs_valid | ds_leave);
    fetch_pc       = br_ev ? br_target : pf_pc;
    fs_to_ds_bus   = {fs_pc, fs_inst};
`ifdef IF_ADEF_CHK_EN
    inst_sram_addr = fetch_pc;
    inst_sram_req  = issue & (fetch_pc[1:0] == 2'b00);
    adef_load      = issue & (fetch_pc[1:0] != 2'b00);
    fs_adef        = fs_valid & adef_r;
`else
    inst_sram_addr = fetch_pc & ~32'd3;
    inst_sram_req  = issue;
    fs_adef        = 1'b0;
`endif
    handshake      = inst_sram_req & inst_sram_addr_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_pc      <= RESET_PC;
      fs_valid   <= 1'b0;
      fs_pc      <= '0;
      fs_inst    <= '0;
      fs_inst_ok <= 1'b0;
      req_pend   <= 1'b0;
      discard    <= 1'b0;
`ifdef IF_ADEF_CHK_EN
      adef_r     <= 1'b0;
`endif
    end else begin
      // Returning data: dropped if already squashed or squashed this cycle.
      if (inst_sram_data_ok && req_pend) begin
        req_pend <= 1'b0;
        if (discard) begin
          discard <= 1'b0;
        end else if (!br_ev) begin
          fs_inst    <= inst_sram_rdata;
          fs_inst_ok <= 1'b1;
        end
      end

      // Squashing an in-flight request: remember to drop its data later.
      if (br_ev && fs_valid && req_pend && !inst_sram_data_ok)
        discard <= 1'b1;

`ifdef IF_ADEF_CHK_EN
      if (handshake || adef_load)
`else
      if (handshake)
`endif
        fs_valid <= 1'b1;
      else if (br_ev || ds_leave)
        fs_valid <= 1'b0;

      if (handshake)
        pf_pc <= inst_sram_addr + 32'd4;
      else if (br_ev)
        pf_pc <= br_target;

      if (handshake) begin
        fs_pc      <= inst_sram_addr;
        fs_inst_ok <= 1'b0;
        req_pend   <= 1'b1;
`ifdef IF_ADEF_CHK_EN
        adef_r     <= 1'b0;
`endif
      end

`ifdef IF_ADEF_CHK_EN
      // Faulting fetch fills the slot directly; pf_pc is left for a redirect.
      if (adef_load) begin
        fs_pc      <= fetch_pc;
        fs_inst    <= '0;
        fs_inst_ok <= 1'b1;
        adef_r     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_stage_sram.sv
// ---------------------------------------------------------------------------
// tb_if_stage_sram
// Bench for if_stage_sram. The bench plays decode (ds_allowin, br_bus) and
// a one-outstanding SRAM slave with random addr_ok and 1..3 cycle data
// latency. The reference model is the architectural instruction stream:
// decode must receive consecutive PCs (+4, 32-bit wrap) starting at RESET_PC
// or at the target of the latest taken branch, each with the memory word for
// that PC. A scoreboard queue holds the next expected item.
// ---------------------------------------------------------------------------
module tb_if_stage_sram;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fs_adef;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage_sram #(
    .RESET_PC(RESET_PC),
    .FS_TO_DS_BUS_WD(64),
    .BR_BUS_WD(33)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ds_allowin(ds_allowin),
    .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus),
    .fs_adef(fs_adef),
    .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int          idle   = 0;
  logic        rst_chk = 1'b0;
  logic        p_hold  = 1'b0;
  logic [63:0] p_bus;

  // slave state
  logic        s_busy  = 1'b0;
  logic        s_stale = 1'b0;
  logic [31:0] s_addr;
  int unsigned s_cnt;
  logic        hs_n = 1'b0;
  logic        dk_n = 1'b0;
  logic [31:0] hs_addr_n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // First item of a fresh stream starting at pc.
  function automatic exp_t stream_start(input logic [31:0] pc);
    exp_t e;
`ifdef IF_ADEF_CHK_EN
    if (pc[1:0] != 2'b00) begin
      e.pc = pc; e.inst = 32'h0; e.adef = 1'b1;
      return e;
    end
    e.pc = pc;
`else
    e.pc = {pc[31:2], 2'b00};
`endif
    e.inst = mem_word(e.pc);
    e.adef = 1'b0;
    return e;
  endfunction

  // A faulting fetch repeats until a redirect; otherwise sequential.
  function automatic exp_t next_of(input exp_t e);
    if (e.adef) return e;
    return stream_start(e.pc + 32'd4);
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = RESET_PC + ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 9) == 0) t = 32'hffff_fff8;
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive a taken branch; it is a branch event only if decode is allowing in.
  task automatic do_branch(input logic [31:0] target);
    br_bus = {1'b1, target};
    if (ds_allowin) begin
      exp_q.delete();
      exp_q.push_back(stream_start(target));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
    if (s_busy) begin
      s_stale = 1'b1;
      s_cnt   = 4;   // its data_ok arrives after reset is released
    end
    exp_q.delete();
    exp_q.push_back(stream_start(RESET_PC));
    @(posedge clk); #3; rst_chk = 1'b1;
    @(posedge clk); #3; rst_chk = 1'b0; reset = 1'b0;
  endtask

  // SRAM slave: one outstanding request, stale data still returned after reset.
  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    forever begin
      @(posedge clk); #2;
      if (dk_n) begin s_busy = 1'b0; s_stale = 1'b0; end
      if (hs_n) begin
        s_busy = 1'b1; s_addr = hs_addr_n; s_cnt = $urandom_range(0, 2);
      end else if (s_busy && s_cnt > 0) begin
        s_cnt--;
      end
      inst_sram_data_ok = s_busy && (s_cnt == 0);
      inst_sram_rdata   = inst_sram_data_ok ? mem_word(s_addr) : $urandom;
      inst_sram_addr_ok = !s_busy && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    hs_n      = inst_sram_req & inst_sram_addr_ok;
    hs_addr_n = inst_sram_addr;
    dk_n      = inst_sram_data_ok;
    if (reset) begin
      p_hold = 1'b0;
      if (rst_chk) begin
        check("rst_valid", fs_to_ds_valid, 0);
        check("rst_req",   inst_sram_req,  0);
        check("rst_adef",  fs_adef,        0);
      end
    end else begin
      if (s_busy && !s_stale)
        check("one_outstanding", inst_sram_req, 0);
`ifndef IF_ADEF_CHK_EN
      if (inst_sram_req) check("addr_align", inst_sram_addr[1:0], 0);
      check("adef_tied", fs_adef, 0);
`endif
      if (fs_to_ds_valid && !ds_allowin) check("stall_no_req", inst_sram_req, 0);
      if (p_hold && !br_bus[32]) begin
        check("hold_valid", fs_to_ds_valid, 1);
        check("hold_bus",   fs_to_ds_bus,   p_bus);
      end
      if (br_bus[32]) check("br_gate", fs_to_ds_valid, 0);
      if (fs_to_ds_valid && ds_allowin) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got pc %h expected no output", fs_to_ds_bus[63:32]);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pc",   fs_to_ds_bus[63:32], mon_e.pc);
          check("out_inst", fs_to_ds_bus[31:0],  mon_e.inst);
          check("out_adef", fs_adef,             mon_e.adef);
          exp_q.push_back(next_of(mon_e));
        end
        n_acc++;
        idle = 0;
      end else begin
        idle++;
      end
      p_hold = fs_to_ds_valid && !ds_allowin;
      p_bus  = fs_to_ds_bus;
      if (idle > 300) begin
        checks++; errors++;
        $display("FAIL progress: got %0d idle cycles expected at most 300", idle);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
    exp_q.push_back(stream_start(RESET_PC));
    @(posedge clk); #3; rst_chk = 1'b1;
    @(posedge clk); #3; rst_chk = 1'b0; reset = 1'b0;

    // Sequential fetch from RESET_PC.
    ds_allowin = 1'b1;
    for (int i = 0; i < 100 && n_acc < 3; i++) begin @(posedge clk); #3; end
    check("first_three", n_acc >= 3, 1);

    // Stall 5 cycles with an instruction buffered.
    for (int i = 0; i < 50 && !(fs_to_ds_valid && !s_busy); i++) begin @(posedge clk); #3; end
    ds_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #3; end
    ds_allowin = 1'b1;

    // Branch while a request is outstanding.
    for (int i = 0; i < 50 && !(s_busy && !s_stale && !inst_sram_data_ok); i++) begin
      @(posedge clk); #3;
    end
    do_branch(32'h1c00_0100);
    @(posedge clk); #3; br_bus = '0;

    // Branch in the same cycle as an address handshake with an empty slot.
    for (int i = 0; i < 100 && !(inst_sram_req && inst_sram_addr_ok && !fs_to_ds_valid); i++) begin
      @(posedge clk); #3;
    end
    do_branch(32'h1c00_0200);
    @(posedge clk); #3; br_bus = '0;

    // Branch with a complete instruction buffered.
    for (int i = 0; i < 50 && !fs_to_ds_valid; i++) begin @(posedge clk); #3; end
    do_branch(32'h1c00_0300);
    @(posedge clk); #3; br_bus = '0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      ds_allowin = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) do_branch(rand_target());
      else br_bus = '0;
    end

    // Reset with a request in flight.
    ds_allowin = 1'b1; br_bus = '0;
    for (int i = 0; i < 50 && !s_busy; i++) begin @(posedge clk); #3; end
    do_reset();
    ds_allowin = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #3;
      ds_allowin = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) do_branch(rand_target());
      else br_bus = '0;
    end
    br_bus = '0; ds_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #3; end

    check("min_accepts", n_acc >= 500, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
